// File: rtl/writeback_stage.sv
// Y86-64 write-back stage: W pipeline register, 15-entry register file,
// status/halt tracking and a saturating retired-instruction counter.
module writeback_stage #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             W_stall,
   input  logic             W_bubble,
   input  logic [3:0]       M_stat,
   input  logic [3:0]       M_icode,
   input  logic [63:0]      M_valE,
   input  logic [63:0]      m_valM,
   input  logic [3:0]       M_dstE,
   input  logic [3:0]       M_dstM,
   input  logic [3:0]       srcA,
   input  logic [3:0]       srcB,
   output logic [63:0]      valA,
   output logic [63:0]      valB,
   output logic [3:0]       W_stat,
   output logic [3:0]       W_icode,
   output logic [3:0]       W_dstE,
   output logic [3:0]       W_dstM,
   output logic [63:0]      W_valE,
   output logic [63:0]      W_valM,
   output logic [3:0]       stat,
   output logic             halted,
   output logic [CNT_W-1:0] retired
);

   localparam logic [3:0] STAT_AOK = 4'd1;
   localparam logic [3:0] STAT_HLT = 4'd2;
   localparam logic [3:0] STAT_ADR = 4'd3;
   localparam logic [3:0] STAT_INS = 4'd4;
   localparam logic [3:0] I_NOP    = 4'd1;
   localparam logic [3:0] R_NONE   = 4'd15;

   logic [3:0]       stat_q, icode_q, dst_e_q, dst_m_q;
   logic [63:0]      val_e_q, val_m_q;
   logic             valid_q;
   logic             halted_q;
   logic [CNT_W-1:0] retired_q;
   logic [63:0]      rf_q [15];

   logic halt_now, freeze, w_hold, commit_ok, retire_d;

   assign halt_now  = (stat_q == STAT_HLT) || (stat_q == STAT_ADR) || (stat_q == STAT_INS);
   // A faulting instruction stays visible in W, so the tail freezes at the
   // same edge that sets halted.
   assign freeze    = halted_q || halt_now;
   assign w_hold    = freeze || W_stall;
   assign commit_ok = !halted_q && (stat_q == STAT_AOK);
   assign retire_d  = commit_ok && valid_q && !W_stall && (retired_q != {CNT_W{1'b1}});

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_q    <= STAT_AOK;
         icode_q   <= I_NOP;
         dst_e_q   <= R_NONE;
         dst_m_q   <= R_NONE;
         val_e_q   <= '0;
         val_m_q   <= '0;
         valid_q   <= 1'b0;
      end else if (w_hold) begin
         stat_q    <= stat_q;
      end else if (W_bubble) begin
         stat_q    <= STAT_AOK;
         icode_q   <= I_NOP;
         dst_e_q   <= R_NONE;
         dst_m_q   <= R_NONE;
         val_e_q   <= '0;
         val_m_q   <= '0;
         valid_q   <= 1'b0;
      end else begin
         stat_q    <= M_stat;
         icode_q   <= M_icode;
         dst_e_q   <= M_dstE;
         dst_m_q   <= M_dstM;
         val_e_q   <= M_valE;
         val_m_q   <= m_valM;
         valid_q   <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         halted_q  <= 1'b0;
         retired_q <= '0;
      end else begin
         if (halt_now)
            halted_q <= 1'b1;
         if (retire_d)
            retired_q <= retired_q + 1'b1;
      end
   end

   // dstM is written after dstE so valM wins on a shared destination.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 15; i++)
            rf_q[i] <= '0;
      end else if (commit_ok) begin
         if (dst_e_q != R_NONE)
            rf_q[dst_e_q] <= val_e_q;
         if (dst_m_q != R_NONE)
            rf_q[dst_m_q] <= val_m_q;
      end
   end

   assign valA    = (srcA != R_NONE) ? rf_q[srcA] : 64'd0;
   assign valB    = (srcB != R_NONE) ? rf_q[srcB] : 64'd0;

   assign W_stat  = stat_q;
   assign W_icode = icode_q;
   assign W_dstE  = dst_e_q;
   assign W_dstM  = dst_m_q;
   assign W_valE  = val_e_q;
   assign W_valM  = val_m_q;
   assign stat    = stat_q;
   assign halted  = halted_q;
   assign retired = retired_q;

endmodule
